// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hold/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MC    = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    // addi x0, x0, 0 -- what a flushed pipeline register loads instead of upstream data
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_hold_ctrl_hazard_detect.sv
// Load-use comparator: EX holds a load whose destination is read by the instruction in ID.
module hazard_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      ex_is_load_in,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_in,
    input  logic                      id_rs1_used_in,
    input  logic                      id_rs2_used_in,
    output logic                      load_use_out
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit      = id_rs1_used_in && (id_rs1_addr_in == ex_rd_addr_in);
        rs2_hit      = id_rs2_used_in && (id_rs2_addr_in == ex_rd_addr_in);
        // x0 is never written, so a load targeting it cannot create a hazard
        load_use_out = ex_is_load_in && (ex_rd_addr_in != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush/redirect controller. Optional hold watchdog under PIPE_HOLD_TIMEOUT_EN.
//   state   | meaning
//   S_RUN   | normal operation
//   S_MC    | multi-cycle execute op in flight
//   S_FLUSH | extra jump bubbles, flush_cnt counts down
module pipe_hold_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_jump_flag_in,
    input  logic [ADDR_WIDTH-1:0]     ex_jump_addr_in,
    input  logic                      ex_is_load_in,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_in,
    input  logic                      id_rs1_used_in,
    input  logic                      id_rs2_used_in,
    input  logic                      ex_mc_start_in,
    input  logic                      ex_mc_done_in,
    input  logic                      bus_wait_in,
    output logic                      pc_hold_out,
    output logic                      if_id_hold_out,
    output logic                      id_ex_hold_out,
    output logic                      ex_mem_hold_out,
    output logic                      if_id_flush_out,
    output logic                      id_ex_flush_out,
    output logic                      ex_mem_flush_out,
    output logic                      pc_jump_flag_out,
    output logic [ADDR_WIDTH-1:0]     pc_jump_addr_out,
    output logic [31:0]               stall_cnt_out,
    output logic                      hold_timeout_out
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("FLUSH_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit hold counter");
    end

    state_e                  state_q, state_d;
    logic [FCW-1:0]          flush_cnt_q, flush_cnt_d;
    logic                    pend_flag_q, pend_flag_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [31:0]             stall_cnt_q, stall_cnt_d;

    logic                    load_use;
    logic                    mc_go;
    logic                    pc_hold_c, if_id_hold_c, id_ex_hold_c, ex_mem_hold_c;
    logic                    if_id_flush_c, id_ex_flush_c, ex_mem_flush_c;
    logic                    jump_c;
    logic [ADDR_WIDTH-1:0]   jump_addr_c;

    hazard_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .ex_is_load_in  (ex_is_load_in),
        .ex_rd_addr_in  (ex_rd_addr_in),
        .id_rs1_addr_in (id_rs1_addr_in),
        .id_rs2_addr_in (id_rs2_addr_in),
        .id_rs1_used_in (id_rs1_used_in),
        .id_rs2_used_in (id_rs2_used_in),
        .load_use_out   (load_use)
    );

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        pend_flag_d    = pend_flag_q;
        pend_addr_d    = pend_addr_q;
        pc_hold_c      = 1'b0;
        if_id_hold_c   = 1'b0;
        id_ex_hold_c   = 1'b0;
        ex_mem_hold_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        jump_c         = 1'b0;
        jump_addr_c    = '0;
        // a jump presented together with mc_start wins; the start is dropped
        mc_go = (state_q == S_MC) || (ex_mc_start_in && !ex_jump_flag_in);

        if (bus_wait_in) begin
            pc_hold_c     = 1'b1;
            if_id_hold_c  = 1'b1;
            id_ex_hold_c  = 1'b1;
            ex_mem_hold_c = 1'b1;
            if (ex_jump_flag_in) begin
                pend_flag_d = 1'b1;
                pend_addr_d = ex_jump_addr_in;
            end
        end else if (mc_go) begin
            pc_hold_c      = 1'b1;
            if_id_hold_c   = 1'b1;
            id_ex_hold_c   = 1'b1;
            ex_mem_flush_c = 1'b1;
            if (state_q != S_MC) begin
                state_d = S_MC;
            end else if (ex_mc_done_in) begin
                state_d = S_RUN;
            end
            // keep any redirect that arrives while held so it is issued afterwards
            if (ex_jump_flag_in) begin
                pend_flag_d = 1'b1;
                pend_addr_d = ex_jump_addr_in;
            end
        end else if (ex_jump_flag_in || pend_flag_q) begin
            jump_c        = 1'b1;
            jump_addr_c   = pend_flag_q ? pend_addr_q : ex_jump_addr_in;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            pend_flag_d   = 1'b0;
            if (FLUSH_CYCLES > 1) begin
                state_d     = S_FLUSH;
                flush_cnt_d = FLUSH_LOAD;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            if (load_use) begin
                pc_hold_c     = 1'b1;
                if_id_hold_c  = 1'b1;
                id_ex_flush_c = 1'b1;
            end
            if (state_q == S_FLUSH) begin
                if_id_flush_c = 1'b1;
                if (flush_cnt_q <= FCW'(1)) begin
                    state_d = S_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCW'(1);
                end
            end
        end
    end

    always_comb begin
        pc_hold_out      = rst && pc_hold_c;
        if_id_hold_out   = rst && if_id_hold_c;
        id_ex_hold_out   = rst && id_ex_hold_c;
        ex_mem_hold_out  = rst && ex_mem_hold_c;
        if_id_flush_out  = rst && if_id_flush_c;
        id_ex_flush_out  = rst && id_ex_flush_c;
        ex_mem_flush_out = rst && ex_mem_flush_c;
        pc_jump_flag_out = rst && jump_c;
        pc_jump_addr_out = rst ? jump_addr_c : '0;
        stall_cnt_d      = stall_cnt_q;
        if (pc_hold_out && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_out = stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            flush_cnt_q <= '0;
            pend_flag_q <= 1'b0;
            pend_addr_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pend_flag_q <= pend_flag_d;
            pend_addr_q <= pend_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef PIPE_HOLD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        hold_cnt_d = '0;
        if (pc_hold_out) begin
            hold_cnt_d = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;
        end
        timeout_d = timeout_q || (hold_cnt_d >= TIMEOUT_LIMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hold_timeout_out = timeout_q;
`else
    assign hold_timeout_out = 1'b0;
`endif

endmodule
